alu_exec_ctrl: RTL and testbench

- Execute-stage controller on the driving side of the core ALU.
- Accepts decoded RV32I instruction fields on a valid/ready handshake, translates them into the 4-bit ALU opcode, and selects the operands.
- Consumes the ALU result and zero flag, then registers a writeback entry and resolves branches and jumps into a one-cycle redirect pulse.
- Sits between the decode stage and the writeback stage; the ALU itself is instantiated alongside it by the parent.

---
 rtl/alu_pkg.sv | 60 ++++++
 rtl/alu_op_decode.sv | 72 +++++++
 rtl/alu_exec_ctrl.sv | 117 +++++++++++
 tb/tb_alu_exec_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings, RV32I opcode/funct3 constants and operand-select types.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SLL  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SRA  = 4'b0111,
        ALU_XOR  = 4'b1000,
        ALU_SUB  = 4'b1010,
        ALU_GE   = 4'b1100,
        ALU_GEU  = 4'b1101,
        ALU_SLT  = 4'b1110,
        ALU_SLTU = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {OPA_RS1, OPA_PC, OPA_ZERO} opa_sel_e;
    typedef enum logic       {OPB_RS2, OPB_IMM}          opb_sel_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // alt selects SUB for funct3=000 and SRA for funct3=101
    function automatic alu_op_e arith_op(input logic [2:0] funct3, input logic alt);
        case (funct3)
            F3_ADD:  arith_op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  arith_op = ALU_SLL;
            F3_SLT:  arith_op = ALU_SLT;
            F3_SLTU: arith_op = ALU_SLTU;
            F3_XOR:  arith_op = ALU_XOR;
            F3_SR:   arith_op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of RV32I opcode fields into ALU opcode, operand selects and class flags.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output alu_op_e    alu_op,
    output opa_sel_e   sel_a,
    output opb_sel_e   sel_b,
    output logic       is_branch,
    output logic       is_jump,
    output logic       is_jalr,
    output logic       illegal
);

    always_comb begin
        alu_op    = ALU_ADD;
        sel_a     = OPA_RS1;
        sel_b     = OPB_RS2;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        is_jalr   = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OPC_OP: alu_op = arith_op(funct3, funct7b5);
            OPC_OP_IMM: begin
                sel_b  = OPB_IMM;
                // bit 30 is part of the immediate except for shifts-right
                alu_op = arith_op(funct3, (funct3 == F3_SR) && funct7b5);
            end
            OPC_LUI: begin
                sel_a = OPA_ZERO;
                sel_b = OPB_IMM;
            end
            OPC_AUIPC: begin
                sel_a = OPA_PC;
                sel_b = OPB_IMM;
            end
            OPC_BRANCH: begin
                is_branch = 1'b1;
                case (funct3)
                    F3_BEQ, F3_BNE: alu_op = ALU_SUB;
                    F3_BLT:         alu_op = ALU_SLT;
                    F3_BGE:         alu_op = ALU_GE;
                    F3_BLTU:        alu_op = ALU_SLTU;
                    F3_BGEU:        alu_op = ALU_GEU;
                    default: begin
                        is_branch = 1'b0;
                        illegal   = 1'b1;
                    end
                endcase
            end
            OPC_JAL: begin
                is_jump = 1'b1;
                sel_a   = OPA_PC;
                sel_b   = OPB_IMM;
            end
            OPC_JALR: begin
                sel_b = OPB_IMM;
                if (funct3 == 3'b000) begin
                    is_jump = 1'b1;
                    is_jalr = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller: drives the ALU, registers one writeback entry and resolves redirects.
module alu_exec_ctrl
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             ex_valid_i,
    output logic             ex_ready_o,
    input  logic [6:0]       opcode_i,
    input  logic [2:0]       funct3_i,
    input  logic             funct7b5_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  rs1_data_i,
    input  logic [XLEN-1:0]  rs2_data_i,
    input  logic [XLEN-1:0]  imm_i,
    input  logic [4:0]       rd_addr_i,
    output logic [3:0]       alu_op_o,
    output logic [XLEN-1:0]  alu_rs1_o,
    output logic [XLEN-1:0]  alu_rs2_o,
    input  logic [XLEN-1:0]  alu_rd_i,
    input  logic             alu_zr_i,
    output logic             wb_valid_o,
    input  logic             wb_ready_i,
    output logic             wb_we_o,
    output logic [4:0]       wb_rd_addr_o,
    output logic [XLEN-1:0]  wb_data_o,
    output logic             redirect_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] retired_o
);

    typedef enum logic {EMPTY, FULL} state_e;

    state_e    state;
    alu_op_e   dec_op;
    opa_sel_e  sel_a;
    opb_sel_e  sel_b;
    logic      is_branch, is_jump, is_jalr, dec_illegal;
    logic      accept, drain, taken;
    logic [XLEN-1:0] link_pc, branch_pc, target;

    alu_op_decode u_dec (
        .opcode    (opcode_i),
        .funct3    (funct3_i),
        .funct7b5  (funct7b5_i),
        .alu_op    (dec_op),
        .sel_a     (sel_a),
        .sel_b     (sel_b),
        .is_branch (is_branch),
        .is_jump   (is_jump),
        .is_jalr   (is_jalr),
        .illegal   (dec_illegal)
    );

    assign ex_ready_o = !flush_i && ((state == EMPTY) || wb_ready_i);
    assign accept     = ex_valid_i && ex_ready_o;
    assign drain      = (state == FULL) && wb_ready_i;
    assign wb_valid_o = (state == FULL);
    assign alu_op_o   = dec_op;

    always_comb begin
        case (sel_a)
            OPA_PC:   alu_rs1_o = pc_i;
            OPA_ZERO: alu_rs1_o = '0;
            default:  alu_rs1_o = rs1_data_i;
        endcase
        alu_rs2_o = (sel_b == OPB_IMM) ? imm_i : rs2_data_i;
    end

    assign link_pc   = pc_i + XLEN'(4);
    assign branch_pc = pc_i + imm_i;
    assign taken     = is_jump || (is_branch && ((funct3_i == F3_BEQ) ? alu_zr_i : !alu_zr_i));

    always_comb begin
        if (is_jalr)      target = alu_rd_i & ~XLEN'(1);
        else if (is_jump) target = alu_rd_i;
        else              target = branch_pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= EMPTY;
            wb_we_o       <= 1'b0;
            wb_rd_addr_o  <= '0;
            wb_data_o     <= '0;
            redirect_o    <= 1'b0;
            redirect_pc_o <= '0;
            illegal_o     <= 1'b0;
            retired_o     <= '0;
        end else if (flush_i) begin
            state      <= EMPTY;
            redirect_o <= 1'b0;
            illegal_o  <= 1'b0;
        end else begin
            redirect_o <= 1'b0;
            illegal_o  <= 1'b0;
            if (drain) retired_o <= retired_o + CNT_W'(1);
            if (accept) begin
                state         <= FULL;
                wb_we_o       <= !dec_illegal && !is_branch && (rd_addr_i != 5'd0);
                wb_rd_addr_o  <= rd_addr_i;
                wb_data_o     <= is_jump ? link_pc : ((dec_illegal || is_branch) ? '0 : alu_rd_i);
                redirect_o    <= taken && !dec_illegal;
                redirect_pc_o <= target;
                illegal_o     <= dec_illegal;
            end else if (drain) begin
                state <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed self-checking bench for alu_exec_ctrl with a behavioural ALU attached.
module tb_alu_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, flush_i, ex_valid_i, funct7b5_i, wb_ready_i;
    logic [6:0]  opcode_i;
    logic [2:0]  funct3_i;
    logic [31:0] pc_i, rs1_data_i, rs2_data_i, imm_i;
    logic [4:0]  rd_addr_i;
    logic        ex_ready_o, alu_zr_i, wb_valid_o, wb_we_o, redirect_o, illegal_o;
    logic [3:0]  alu_op_o;
    logic [31:0] alu_rs1_o, alu_rs2_o, alu_rd_i, wb_data_o, redirect_pc_o, retired_o;
    logic [4:0]  wb_rd_addr_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_exec_ctrl #(.XLEN(32), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
        .opcode_i(opcode_i), .funct3_i(funct3_i), .funct7b5_i(funct7b5_i),
        .pc_i(pc_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .imm_i(imm_i), .rd_addr_i(rd_addr_i),
        .alu_op_o(alu_op_o), .alu_rs1_o(alu_rs1_o), .alu_rs2_o(alu_rs2_o),
        .alu_rd_i(alu_rd_i), .alu_zr_i(alu_zr_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_we_o(wb_we_o),
        .wb_rd_addr_o(wb_rd_addr_o), .wb_data_o(wb_data_o),
        .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
        .illegal_o(illegal_o), .retired_o(retired_o)
    );

    // Stand-in for the real ALU
    always_comb begin
        case (alu_op_o)
            4'b0000: alu_rd_i = alu_rs1_o & alu_rs2_o;
            4'b0001: alu_rd_i = alu_rs1_o | alu_rs2_o;
            4'b0010: alu_rd_i = alu_rs1_o + alu_rs2_o;
            4'b0100: alu_rd_i = alu_rs1_o << alu_rs2_o[4:0];
            4'b0101: alu_rd_i = alu_rs1_o >> alu_rs2_o[4:0];
            4'b0111: alu_rd_i = $unsigned($signed(alu_rs1_o) >>> alu_rs2_o[4:0]);
            4'b1000: alu_rd_i = alu_rs1_o ^ alu_rs2_o;
            4'b1010: alu_rd_i = alu_rs1_o - alu_rs2_o;
            4'b1100: alu_rd_i = {31'd0, $signed(alu_rs1_o) >= $signed(alu_rs2_o)};
            4'b1101: alu_rd_i = {31'd0, alu_rs1_o >= alu_rs2_o};
            4'b1110: alu_rd_i = {31'd0, $signed(alu_rs1_o) < $signed(alu_rs2_o)};
            4'b1111: alu_rd_i = {31'd0, alu_rs1_o < alu_rs2_o};
            default: alu_rd_i = '0;
        endcase
        alu_zr_i = (alu_rd_i == '0);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic b5,
                         input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [4:0] rd);
        ex_valid_i = 1'b1;
        opcode_i = opc; funct3_i = f3; funct7b5_i = b5;
        pc_i = pc; rs1_data_i = a; rs2_data_i = b; imm_i = imm; rd_addr_i = rd;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush_i = 1'b0; ex_valid_i = 1'b0; wb_ready_i = 1'b1;
        opcode_i = '0; funct3_i = '0; funct7b5_i = 1'b0;
        pc_i = '0; rs1_data_i = '0; rs2_data_i = '0; imm_i = '0; rd_addr_i = '0;
        #12;
        check_eq("rst_wb_valid", {31'd0, wb_valid_o}, 32'd0);
        check_eq("rst_retired", retired_o, 32'd0);
        check_eq("rst_ready", {31'd0, ex_ready_o}, 32'd1);
        rst_n = 1'b1;
        step();

        // ADD x3 = 5 + 7
        drive(7'b0110011, 3'b000, 1'b0, 32'h0, 32'd5, 32'd7, 32'h0, 5'd3);
        check_eq("add_op", {28'd0, alu_op_o}, 32'h2);
        step(); ex_valid_i = 1'b0;
        check_eq("add_valid", {31'd0, wb_valid_o}, 32'd1);
        check_eq("add_data", wb_data_o, 32'd12);
        check_eq("add_we", {31'd0, wb_we_o}, 32'd1);
        check_eq("add_rd", {27'd0, wb_rd_addr_o}, 32'd3);
        step();
        check_eq("add_retired", retired_o, 32'd1);
        check_eq("add_empty", {31'd0, wb_valid_o}, 32'd0);

        // SUB x4 = 3 - 5
        drive(7'b0110011, 3'b000, 1'b1, 32'h0, 32'd3, 32'd5, 32'h0, 5'd4);
        check_eq("sub_op", {28'd0, alu_op_o}, 32'hA);
        step(); ex_valid_i = 1'b0;
        check_eq("sub_data", wb_data_o, 32'hFFFF_FFFE);
        step();

        // BEQ taken
        drive(7'b1100011, 3'b000, 1'b0, 32'h100, 32'd9, 32'd9, 32'h20, 5'd7);
        check_eq("beq_op", {28'd0, alu_op_o}, 32'hA);
        step(); ex_valid_i = 1'b0;
        check_eq("beq_redir", {31'd0, redirect_o}, 32'd1);
        check_eq("beq_pc", redirect_pc_o, 32'h120);
        check_eq("beq_we", {31'd0, wb_we_o}, 32'd0);
        step();
        check_eq("beq_pulse", {31'd0, redirect_o}, 32'd0);

        // BNE with equal operands: not taken
        drive(7'b1100011, 3'b001, 1'b0, 32'h100, 32'd9, 32'd9, 32'h20, 5'd0);
        step(); ex_valid_i = 1'b0;
        check_eq("bne_redir", {31'd0, redirect_o}, 32'd0);
        step();

        // BLT (-1 < 1) taken, then BLTU back-to-back not taken
        drive(7'b1100011, 3'b100, 1'b0, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 5'd0);
        check_eq("blt_op", {28'd0, alu_op_o}, 32'hE);
        step();
        check_eq("blt_redir", {31'd0, redirect_o}, 32'd1);
        drive(7'b1100011, 3'b110, 1'b0, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 5'd0);
        check_eq("bltu_op", {28'd0, alu_op_o}, 32'hF);
        step(); ex_valid_i = 1'b0;
        check_eq("bltu_redir", {31'd0, redirect_o}, 32'd0);
        step();
        check_eq("br_retired", retired_o, 32'd6);

        // Backpressure: ADDI x1 = x0 + (-1) with bit 30 set in the immediate
        wb_ready_i = 1'b0;
        drive(7'b0010011, 3'b000, 1'b1, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 5'd1);
        check_eq("addi_op", {28'd0, alu_op_o}, 32'h2);
        step(); ex_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("bp_data", wb_data_o, 32'hFFFF_FFFF);
            check_eq("bp_ready", {31'd0, ex_ready_o}, 32'd0);
            step();
        end
        check_eq("bp_retired", retired_o, 32'd6);
        wb_ready_i = 1'b1;
        drive(7'b0110111, 3'b000, 1'b0, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'h1234_5000, 5'd2);
        check_eq("lui_ready", {31'd0, ex_ready_o}, 32'd1);
        step(); ex_valid_i = 1'b0;
        check_eq("lui_data", wb_data_o, 32'h1234_5000);
        check_eq("lui_rd", {27'd0, wb_rd_addr_o}, 32'd2);
        step();
        check_eq("b2b_retired", retired_o, 32'd8);

        // JALR then flush of the pending entry
        drive(7'b1100111, 3'b000, 1'b0, 32'h200, 32'h1003, 32'h0, 32'h4, 5'd1);
        step(); ex_valid_i = 1'b0;
        check_eq("jalr_redir", {31'd0, redirect_o}, 32'd1);
        check_eq("jalr_pc", redirect_pc_o, 32'h1006);
        check_eq("jalr_link", wb_data_o, 32'h204);
        flush_i = 1'b1; #1;
        check_eq("flush_ready", {31'd0, ex_ready_o}, 32'd0);
        step(); flush_i = 1'b0;
        check_eq("flush_valid", {31'd0, wb_valid_o}, 32'd0);
        check_eq("flush_retired", retired_o, 32'd8);

        // Flush during an acceptance attempt captures nothing
        flush_i = 1'b1;
        drive(7'b0110011, 3'b000, 1'b0, 32'h0, 32'd1, 32'd1, 32'h0, 5'd5);
        step(); flush_i = 1'b0; ex_valid_i = 1'b0;
        check_eq("flush_acc", {31'd0, wb_valid_o}, 32'd0);

        // Illegal opcode held under backpressure, then reset mid-FULL
        wb_ready_i = 1'b0;
        drive(7'h7F, 3'b000, 1'b0, 32'h300, 32'd1, 32'd2, 32'h0, 5'd5);
        step(); ex_valid_i = 1'b0;
        check_eq("ill_pulse", {31'd0, illegal_o}, 32'd1);
        check_eq("ill_we", {31'd0, wb_we_o}, 32'd0);
        check_eq("ill_valid", {31'd0, wb_valid_o}, 32'd1);
        step();
        check_eq("ill_once", {31'd0, illegal_o}, 32'd0);
        check_eq("ill_held", {31'd0, wb_valid_o}, 32'd1);
        #2 rst_n = 1'b0; #1;
        check_eq("mrst_valid", {31'd0, wb_valid_o}, 32'd0);
        check_eq("mrst_retired", retired_o, 32'd0);
        check_eq("mrst_rpc", redirect_pc_o, 32'd0);
        check_eq("mrst_rd", {27'd0, wb_rd_addr_o}, 32'd0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
